// File: rtl/pad_cfg_pkg.sv
// Shared constants and types for the pad configuration register block:
// register offsets, CTRL bit positions and the per-pad select type.
package pad_cfg_pkg;

  localparam int NBIT_PADMUX_DFLT = 2;

  typedef logic [NBIT_PADMUX_DFLT-1:0] pad_sel_t;

  localparam logic [11:0] PADMUX_BASE = 12'h000;
  localparam logic [11:0] CTRL        = 12'h400;
  localparam logic [11:0] STATUS      = 12'h404;
  localparam logic [11:0] IO_IN_LO    = 12'h408;
  localparam logic [11:0] IO_IN_HI    = 12'h40C;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CTRL_LOCK_BIT   = 2;

endpackage

// File: rtl/pad_cfg_regs_if.sv
// APB slave bus bundle for pad_cfg_regs; signal names follow the block's pin list.
interface pad_cfg_regs_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [31:0]               pwdata_i;
  logic                      pwrite_i;
  logic                      psel_i;
  logic                      penable_i;
  logic [31:0]               prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    output prdata_o, pready_o, pslverr_o
  );

  modport master (
    output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
    input  prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/pad_cfg_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pad input levels.
module pad_cfg_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // two-stage capture of the raw inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pad_cfg_regs.sv
// APB pad-mux configuration registers with shadow/active selects and atomic commit.
// Optional sticky write lock enabled by defining PAD_CFG_LOCK_EN.
module pad_cfg_regs
  import pad_cfg_pkg::*;
#(
  parameter int N_IO           = 48,
  parameter int NBIT_PADMUX    = 2,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  pad_cfg_regs_if.slave               apb,
  output logic [N_IO*NBIT_PADMUX-1:0] pad_mux_o,
  input  logic [N_IO-1:0]             io_in_i,
  output logic                        update_o
);

  localparam int MUXW = N_IO * NBIT_PADMUX;
  localparam int AW   = APB_ADDR_WIDTH;

  logic [MUXW-1:0] shadow_q, shadow_d, active_q, active_d;
  logic            auto_q, auto_d, update_q, update_d, lock_q;
  logic [N_IO-1:0] io_sync_s;
  logic [63:0]     io_ext_s;
  logic [AW-1:0]   addr_s, pad_off_s;
  logic            access_s, hit_pad_s, hit_ctrl_s, hit_status_s, hit_lo_s, hit_hi_s;
  logic            err_s, wr_pad_s, wr_ctrl_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  pad_cfg_sync #(.WIDTH(N_IO)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (io_in_i),
    .q_o    (io_sync_s)
  );

  assign io_ext_s  = 64'(io_sync_s);
  assign addr_s    = {apb.paddr_i[AW-1:2], 2'b00};
  assign pad_off_s = addr_s - AW'(PADMUX_BASE);
  assign access_s  = apb.psel_i & apb.penable_i;

  // address decode and error classification; a locked write is rejected like a read-only one
  always_comb begin
    hit_pad_s    = (pad_off_s < AW'(4 * N_IO));
    hit_ctrl_s   = (addr_s == AW'(CTRL));
    hit_status_s = (addr_s == AW'(STATUS));
    hit_lo_s     = (addr_s == AW'(IO_IN_LO));
    hit_hi_s     = (addr_s == AW'(IO_IN_HI));
    err_s        = access_s & (
                     ~(hit_pad_s | hit_ctrl_s | hit_status_s | hit_lo_s | hit_hi_s)
                   | (apb.pwrite_i & (hit_status_s | hit_lo_s | hit_hi_s))
                   | (apb.pwrite_i & lock_q & (hit_pad_s | hit_ctrl_s)));
    wr_pad_s     = access_s & apb.pwrite_i & hit_pad_s & ~lock_q;
    wr_ctrl_s    = access_s & apb.pwrite_i & hit_ctrl_s & ~lock_q;
  end

  // read data mux, zero outside a clean read access
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (access_s && !apb.pwrite_i && !err_s) begin
      if (hit_pad_s) begin
        for (int k = 0; k < N_IO; k++) begin
          if (pad_off_s[AW-1:2] == (AW-2)'(k)) begin
            rdata_s[NBIT_PADMUX-1:0] = shadow_q[k*NBIT_PADMUX +: NBIT_PADMUX];
          end else begin
            rdata_s = rdata_s;
          end
        end
      end else if (hit_ctrl_s) begin
        rdata_s[CTRL_AUTO_BIT] = auto_q;
        rdata_s[CTRL_LOCK_BIT] = lock_q;
      end else if (hit_status_s) begin
        rdata_s[0] = (shadow_q != active_q);
      end else if (hit_lo_s) begin
        rdata_s = io_ext_s[31:0];
      end else begin
        rdata_s = io_ext_s[63:32];
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // commit uses the pre-edge shadows and AUTO; the new AUTO value applies from the next access
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    auto_d   = auto_q;
    if (wr_ctrl_s) begin
      if (apb.pwdata_i[CTRL_COMMIT_BIT]) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
      auto_d = apb.pwdata_i[CTRL_AUTO_BIT];
    end else begin
      auto_d = auto_q;
    end
    for (int k = 0; k < N_IO; k++) begin
      if (wr_pad_s && (pad_off_s[AW-1:2] == (AW-2)'(k))) begin
        shadow_d[k*NBIT_PADMUX +: NBIT_PADMUX] = apb.pwdata_i[NBIT_PADMUX-1:0];
        if (auto_q) begin
          active_d[k*NBIT_PADMUX +: NBIT_PADMUX] = apb.pwdata_i[NBIT_PADMUX-1:0];
        end else begin
          active_d = active_d;
        end
      end else begin
        shadow_d = shadow_d;
      end
    end
    update_d = (active_d != active_q);
  end

  // configuration state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      auto_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      auto_q   <= auto_d;
      update_q <= update_d;
    end
  end

`ifdef PAD_CFG_LOCK_EN
  logic lock_d;

  // sticky lock, cleared only by reset
  always_comb begin
    lock_d = lock_q | (wr_ctrl_s & apb.pwdata_i[CTRL_LOCK_BIT]);
  end

  // lock register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign unused_s = ^{apb.paddr_i[1:0], apb.pwdata_i[31:3]};
`else
  assign lock_q   = 1'b0;
  assign unused_s = ^{apb.paddr_i[1:0], apb.pwdata_i[31:2]};
`endif

  assign apb.prdata_o  = rdata_s;
  assign apb.pslverr_o = err_s;
  assign apb.pready_o  = access_s;
  assign pad_mux_o     = active_q;
  assign update_o      = update_q;

endmodule

// File: tb/tb_pad_cfg_regs.sv
// Directed self-checking bench for pad_cfg_regs; lock checks follow PAD_CFG_LOCK_EN.
module tb_pad_cfg_regs;

  localparam int N_IO = 48;
  localparam int NB   = 2;
  localparam int MUXW = N_IO * NB;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [MUXW-1:0] pad_mux_o;
  logic [N_IO-1:0] io_in_i;
  logic            update_o;
  logic [MUXW-1:0] exp_mux;
  logic [31:0]     rd;
  logic            er;
  int              n_total = 0;
  int              n_bad   = 0;

  pad_cfg_regs_if #(.APB_ADDR_WIDTH(12)) apb ();

  pad_cfg_regs #(.N_IO(N_IO), .NBIT_PADMUX(NB), .APB_ADDR_WIDTH(12)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .apb       (apb),
    .pad_mux_o (pad_mux_o),
    .io_in_i   (io_in_i),
    .update_o  (update_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(negedge clk_i);
    apb.psel_i = 1'b1; apb.pwrite_i = 1'b1; apb.paddr_i = a; apb.pwdata_i = d; apb.penable_i = 1'b0;
    @(negedge clk_i);
    apb.penable_i = 1'b1;
    #2 err = apb.pslverr_o;
    @(posedge clk_i);
    #1 apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(negedge clk_i);
    apb.psel_i = 1'b1; apb.pwrite_i = 1'b0; apb.paddr_i = a; apb.penable_i = 1'b0;
    @(negedge clk_i);
    apb.penable_i = 1'b1;
    #2 d = apb.prdata_o; err = apb.pslverr_o;
    @(posedge clk_i);
    #1 apb.psel_i = 1'b0; apb.penable_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; io_in_i = '0;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    apb.paddr_i = 12'h000; apb.pwdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;

    // reset state
    check_val("rst_mux", pad_mux_o, 128'h0);
    check_val("rst_upd", update_o, 128'h0);
    apb_read(12'h000, rd, er);
    check_val("rst_pad0", rd, 128'h0);
    check_val("rst_pad0_err", er, 128'h0);
    apb_read(12'h404, rd, er);
    check_val("rst_status", rd, 128'h0);

    // shadow write then commit
    apb_write(12'h008, 32'd2, er);
    check_val("wr_pad2_err", er, 128'h0);
    apb_read(12'h008, rd, er);
    check_val("rd_pad2", rd, 128'h2);
    apb_read(12'h404, rd, er);
    check_val("pending", rd, 128'h1);
    check_val("pad2_not_active", pad_mux_o[5:4], 128'h0);
    apb_write(12'h400, 32'h1, er);
    check_val("commit_pad2", pad_mux_o[5:4], 128'h2);
    check_val("commit_upd", update_o, 128'h1);
    @(posedge clk_i); #1;
    check_val("commit_upd_end", update_o, 128'h0);
    apb_read(12'h404, rd, er);
    check_val("not_pending", rd, 128'h0);

    // AUTO mode
    apb_write(12'h400, 32'h2, er);
    check_val("auto_on_noupd", update_o, 128'h0);
    apb_write(12'h0BC, 32'h3, er);
    check_val("auto_pad47", pad_mux_o[95:94], 128'h3);
    check_val("auto_upd", update_o, 128'h1);
    apb_read(12'h400, rd, er);
    check_val("ctrl_auto", rd, 128'h2);
    apb_write(12'h0BC, 32'h3, er);
    check_val("same_val_noupd", update_o, 128'h0);
    apb_write(12'h400, 32'h3, er);
    check_val("nop_commit_noupd", update_o, 128'h0);

    // consecutive active changes keep update high
    @(negedge clk_i);
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b1;
    apb.paddr_i = 12'h000; apb.pwdata_i = 32'h1;
    @(posedge clk_i); #1;
    check_val("b2b_pad0_a", pad_mux_o[1:0], 128'h1);
    apb.pwdata_i = 32'h2;
    @(posedge clk_i); #1;
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    check_val("b2b_pad0_b", pad_mux_o[1:0], 128'h2);
    check_val("b2b_upd", update_o, 128'h1);
    @(posedge clk_i); #1;
    check_val("b2b_upd_end", update_o, 128'h0);

    // synchroniser latency
    @(negedge clk_i);
    apb.psel_i = 1'b1; apb.penable_i = 1'b1; apb.pwrite_i = 1'b0; apb.paddr_i = 12'h408;
    io_in_i = 48'hA5A5_0000_0001;
    #2 check_val("io_0edge", apb.prdata_o, 128'h0);
    @(posedge clk_i); #1;
    check_val("io_1edge", apb.prdata_o, 128'h0);
    @(posedge clk_i); #1;
    check_val("io_lo", apb.prdata_o, 128'h1);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    apb_read(12'h40C, rd, er);
    check_val("io_hi", rd, 128'hA5A5);

    // error responses
    exp_mux = '0; exp_mux[95:94] = 2'd3; exp_mux[5:4] = 2'd2; exp_mux[1:0] = 2'd2;
    apb_read(12'h500, rd, er);
    check_val("unmap_err", er, 128'h1);
    check_val("unmap_data", rd, 128'h0);
    apb_write(12'h404, 32'h1, er);
    check_val("ro_wr_err", er, 128'h1);
    apb_write(12'h0C0, 32'h3, er);
    check_val("pad48_wr_err", er, 128'h1);
    apb_read(12'h0C0, rd, er);
    check_val("pad48_rd_err", er, 128'h1);
    check_val("pad48_rd_data", rd, 128'h0);
    check_val("err_mux_same", pad_mux_o, exp_mux);
    apb_read(12'h404, rd, er);
    check_val("err_status_same", rd, 128'h0);

    // commit and AUTO change in one write
    apb_write(12'h400, 32'h0, er);
    apb_write(12'h004, 32'h3, er);
    check_val("pad1_shadow_only", pad_mux_o[3:2], 128'h0);
    apb_write(12'h400, 32'h3, er);
    check_val("commit_auto_pad1", pad_mux_o[3:2], 128'h3);
    check_val("commit_auto_upd", update_o, 128'h1);
    apb_read(12'h400, rd, er);
    check_val("commit_auto_ctrl", rd, 128'h2);
    apb_write(12'h004, 32'h1, er);
    check_val("auto_after_commit", pad_mux_o[3:2], 128'h1);

    // reset mid-transfer
    @(negedge clk_i);
    apb.psel_i = 1'b1; apb.pwrite_i = 1'b1; apb.paddr_i = 12'h008; apb.pwdata_i = 32'h1; apb.penable_i = 1'b0;
    @(negedge clk_i);
    apb.penable_i = 1'b1;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    rst_ni = 1'b1;
    check_val("midrst_mux", pad_mux_o, 128'h0);
    check_val("midrst_upd", update_o, 128'h0);
    apb_read(12'h008, rd, er);
    check_val("midrst_pad2", rd, 128'h0);
    apb_read(12'h400, rd, er);
    check_val("midrst_ctrl", rd, 128'h0);

`ifdef PAD_CFG_LOCK_EN
    apb_write(12'h400, 32'h4, er);
    check_val("lock_set_err", er, 128'h0);
    apb_read(12'h400, rd, er);
    check_val("lock_rd", rd, 128'h4);
    apb_write(12'h000, 32'h1, er);
    check_val("locked_wr_err", er, 128'h1);
    apb_read(12'h000, rd, er);
    check_val("locked_pad0", rd, 128'h0);
    apb_write(12'h400, 32'h3, er);
    check_val("locked_ctrl_err", er, 128'h1);
    check_val("locked_no_commit", update_o, 128'h0);
    @(negedge clk_i) rst_ni = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    apb_read(12'h400, rd, er);
    check_val("unlock_ctrl", rd, 128'h0);
    apb_write(12'h000, 32'h1, er);
    check_val("unlock_wr_err", er, 128'h0);
`else
    apb_write(12'h400, 32'h4, er);
    check_val("nolock_err", er, 128'h0);
    apb_read(12'h400, rd, er);
    check_val("nolock_rd", rd, 128'h0);
    apb_write(12'h000, 32'h1, er);
    check_val("nolock_wr_err", er, 128'h0);
`endif
    apb_read(12'h000, rd, er);
    check_val("final_pad0", rd, 128'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
